// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: one byte-enabled write port and one registered read port.
interface param_reg_file_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NBYTES = WIDTH / 8;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NBYTES-1:0] wr_be;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_err;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, wr_err
  );
endinterface

// File: rtl/param_reg_file.sv
// DEPTH x WIDTH scratch register file: byte-enabled write, 1-cycle registered read,
// configurable same-address read/write ordering and out-of-range error flags.
module param_reg_file #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WRITE_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  param_reg_file_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_fwd;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_new;

  // Range checks, byte merge and same-address forwarding decision.
  always_comb begin
    wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_C);
    rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);
    wr_ok       = bus.wr_en && wr_in_range;
    wr_old      = wr_in_range ? mem[bus.wr_addr] : '0;
    wr_new      = wr_old;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (bus.wr_be[b]) wr_new[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
    rd_fwd = (WRITE_FIRST != 0) && wr_ok && rd_in_range && (bus.rd_addr == bus.wr_addr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      if (wr_ok) mem[bus.wr_addr] <= wr_new;
      bus.wr_err   <= bus.wr_en && !wr_in_range;
      bus.rd_valid <= bus.rd_en;
      bus.rd_err   <= bus.rd_en && !rd_in_range;
      // Out-of-range reads return zero; rd_data holds when no read is issued.
      if (bus.rd_en) begin
        if (!rd_in_range)  bus.rd_data <= '0;
        else if (rd_fwd)   bus.rd_data <= wr_new;
        else               bus.rd_data <= mem[bus.rd_addr];
      end
    end
  end
endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: write-first and read-first instances (DEPTH=6) share stimulus,
// expectations come from a reference array model via a scoreboard queue.
module tb_param_reg_file;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 6;

  typedef struct packed {
    logic        v1, e1, w1;
    logic [15:0] d1;
    logic        v0, e0, w0;
    logic [15:0] d0;
  } obs_t;

  logic clk;
  logic reset;

  param_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();
  param_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();

  param_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  param_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE_FIRST(0)) dut_rf (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];
  logic [15:0] model [DEPTH];
  logic [15:0] last1, last0;

  function automatic obs_t sample();
    sample = '{bus1.rd_valid, bus1.rd_err, bus1.wr_err, bus1.rd_data,
               bus0.rd_valid, bus0.rd_err, bus0.wr_err, bus0.rd_data};
  endfunction

  // Drive one cycle on both DUTs, push the model's expectation, step past the edge.
  task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [1:0] be, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra);
    obs_t        e;
    logic [15:0] merged;
    reset = rst;
    bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_be = be; bus1.wr_data = wd;
    bus1.rd_en = re; bus1.rd_addr = ra;
    bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_be = be; bus0.wr_data = wd;
    bus0.rd_en = re; bus0.rd_addr = ra;
    e = '0;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      last1 = '0; last0 = '0;
    end else begin
      merged = '0;
      if (wa < 3'(DEPTH)) begin
        merged = model[wa];
        if (be[0]) merged[7:0]  = wd[7:0];
        if (be[1]) merged[15:8] = wd[15:8];
      end
      e.w1 = we && (wa >= 3'(DEPTH));
      e.w0 = e.w1;
      if (re) begin
        e.v1 = 1'b1; e.v0 = 1'b1;
        if (ra >= 3'(DEPTH)) begin
          e.e1 = 1'b1; e.e0 = 1'b1;
          last1 = '0; last0 = '0;
        end else begin
          last0 = model[ra];
          last1 = (we && wa < 3'(DEPTH) && wa == ra) ? merged : model[ra];
        end
      end
      e.d1 = last1; e.d0 = last0;
      if (we && wa < 3'(DEPTH)) model[wa] = merged;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    drive(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 1'b0, 3'd0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== 64'(0) || o !== e) begin
      errors++; $display("FAIL reset_state: got %h required %h", o, e);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'(a));
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e || !o.v1 || o.d1 !== 16'h0000) begin
        errors++; $display("FAIL reset_read addr %0d: got %h required %h", a, o, e);
      end
    end
  endtask

  task automatic test_byte_enable();
    obs_t e, o;
    drive(1'b0, 1'b1, 3'd3, 2'b11, 16'hBEEF, 1'b0, 3'd0);
    void'(sb.pop_front());
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd3);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'hBEEF || o.d0 !== 16'hBEEF) begin
      errors++; $display("FAIL full_write: got %h required %h", o, e);
    end
    drive(1'b0, 1'b1, 3'd3, 2'b01, 16'h1234, 1'b0, 3'd0);
    void'(sb.pop_front());
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd3);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'hBE34 || o.d0 !== 16'hBE34) begin
      errors++; $display("FAIL byte_merge: got %h required %h", o, e);
    end
  endtask

  task automatic test_same_cycle();
    obs_t e, o;
    drive(1'b0, 1'b1, 3'd5, 2'b11, 16'hA5A5, 1'b1, 3'd5);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'hA5A5 || o.d0 !== 16'h0000) begin
      errors++; $display("FAIL same_addr_rw: got %h required %h", o, e);
    end
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd5);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'hA5A5 || o.d0 !== 16'hA5A5) begin
      errors++; $display("FAIL same_addr_after: got %h required %h", o, e);
    end
  endtask

  task automatic test_out_of_range();
    obs_t e, o;
    drive(1'b0, 1'b1, 3'd7, 2'b11, 16'hDEAD, 1'b0, 3'd0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || !o.w1 || !o.w0) begin
      errors++; $display("FAIL wr_err_set: got %h required %h", o, e);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'(a));
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL oor_no_change addr %0d: got %h required %h", a, o, e);
      end
    end
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd6);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || !o.v1 || !o.e1 || o.d1 !== 16'h0 || o.w1) begin
      errors++; $display("FAIL rd_err: got %h required %h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [15:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    for (int a = 0; a < 3; a++) begin
      drive(1'b0, 1'b1, 3'(a), 2'b11, vals[a], 1'b0, 3'd0);
      void'(sb.pop_front());
    end
    for (int a = 0; a < 3; a++) begin
      drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'(a));
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e || !o.v1 || o.d1 !== vals[a]) begin
        errors++; $display("FAIL back_to_back %0d: got %h required %h", a, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    drive(1'b0, 1'b1, 3'd4, 2'b11, 16'h4444, 1'b0, 3'd0);
    void'(sb.pop_front());
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd4);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'h4444) begin
      errors++; $display("FAIL pre_reset_read: got %h required %h", o, e);
    end
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd4);
    void'(sb.pop_front());
    drive(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 1'b0, 3'd0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.v1 || o.d1 !== 16'h0) begin
      errors++; $display("FAIL reset_discards_read: got %h required %h", o, e);
    end
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 1'b1, 3'd4);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.d1 !== 16'h0 || o.d0 !== 16'h0) begin
      errors++; $display("FAIL reset_clears_entry: got %h required %h", o, e);
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    logic [2:0] wa, ra;
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 99) == 0), 1'($urandom), wa, 2'($urandom),
            16'($urandom), 1'($urandom), ra);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        if (bad < 10) $display("FAIL random cycle %0d: got %h required %h", n, o, e);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_be = '0; bus1.wr_data = '0;
    bus1.rd_en = 1'b0; bus1.rd_addr = '0;
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_be = '0; bus0.wr_data = '0;
    bus0.rd_en = 1'b0; bus0.rd_addr = '0;
    last1 = '0; last0 = '0;
    test_reset();
    test_byte_enable();
    test_same_cycle();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
